// File: rtl/matmul_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_ctrl_if
//  Description : Element-stream bundle for the matrix-multiply controller.
//                Carries the operand input stream (s_*) and the result
//                output stream (m_*). The controller uses the slave view;
//                the producer/consumer side uses the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface matmul_ctrl_if #(
    parameter int WIDTH = 8
);
    // Operand input stream
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    // Result output stream
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    // Producer of operands / consumer of results
    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

    // Controller side
    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );
endinterface

`default_nettype wire

// File: rtl/matmul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_ctrl
//  Description : Sequencer and stream adapter for a registered-tree NxN
//                matrix multiplier core. Loads A then B (row-major) from a
//                serial stream into operand registers, waits out the core
//                latency, captures the flat product and replays it as a
//                serial stream with last-beat marking. One product in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_ctrl #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = $clog2(N)
) (
    input  wire logic                 clk,
    input  wire logic                 rstn,
    matmul_ctrl_if.slave              bus,
    output logic [N*N*WIDTH-1:0]      A_flat,
    output logic [N*N*WIDTH-1:0]      B_flat,
    input  wire logic [N*N*WIDTH-1:0] C_flat,
    output logic                      busy,
    output logic                      done
);

    // ------------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------------
    localparam int NN     = N * N;
    localparam int IN_W   = $clog2(2 * NN);
    localparam int OUT_W  = $clog2(NN);
    // A zero-latency core still needs a one-bit wait counter (one cycle).
    localparam int WAIT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [1:0] c_ST_LOAD    = 2'd0;
    localparam logic [1:0] c_ST_COMPUTE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN   = 2'd2;

    localparam logic [IN_W-1:0]   c_IN_LAST   = IN_W'(2 * NN - 1);
    localparam logic [IN_W-1:0]   c_IN_B_BASE = IN_W'(NN);
    localparam logic [OUT_W-1:0]  c_OUT_LAST  = OUT_W'(NN - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(LATENCY);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [IN_W-1:0]   r_in_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [OUT_W-1:0]  r_out_cnt;
    logic              r_done;

    logic [WIDTH-1:0]  r_a [NN];
    logic [WIDTH-1:0]  r_b [NN];
    logic [WIDTH-1:0]  r_c [NN];

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic              w_in_load;
    logic              w_in_drain;
    logic              w_s_fire;
    logic              w_m_fire;
    logic              w_in_is_b;
    logic [OUT_W-1:0]  w_a_idx;
    logic [OUT_W-1:0]  w_b_idx;
    logic              w_capture;

    assign w_in_load  = (r_state == c_ST_LOAD);
    assign w_in_drain = (r_state == c_ST_DRAIN);
    assign w_s_fire   = w_in_load && bus.s_valid;
    assign w_m_fire   = w_in_drain && bus.m_ready;

    // Beats 0..NN-1 address A, beats NN..2NN-1 address B.
    assign w_in_is_b  = (r_in_cnt >= c_IN_B_BASE);
    assign w_a_idx    = OUT_W'(r_in_cnt);
    assign w_b_idx    = OUT_W'(r_in_cnt - c_IN_B_BASE);

    // The core output is settled during the last COMPUTE cycle.
    assign w_capture  = (r_state == c_ST_COMPUTE) && (r_wait_cnt == c_WAIT_LAST);

    // Control FSM: load counter, latency wait, drain counter and done pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_ST_LOAD;
            r_in_cnt   <= '0;
            r_wait_cnt <= '0;
            r_out_cnt  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_LOAD: begin
                    if (w_s_fire) begin
                        if (r_in_cnt == c_IN_LAST) begin
                            r_in_cnt   <= '0;
                            r_wait_cnt <= '0;
                            r_state    <= c_ST_COMPUTE;
                        end else begin
                            r_in_cnt <= r_in_cnt + 1'b1;
                        end
                    end
                end
                c_ST_COMPUTE: begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        r_wait_cnt <= '0;
                        r_state    <= c_ST_DRAIN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                c_ST_DRAIN: begin
                    if (w_m_fire) begin
                        if (r_out_cnt == c_OUT_LAST) begin
                            r_out_cnt <= '0;
                            r_done    <= 1'b1;
                            r_state   <= c_ST_LOAD;
                        end else begin
                            r_out_cnt <= r_out_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_LOAD;
                end
            endcase
        end
    end

    // Operand registers: written only by accepted load beats, otherwise held
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NN; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (w_s_fire) begin
            if (w_in_is_b) begin
                r_b[w_b_idx] <= bus.s_data;
            end else begin
                r_a[w_a_idx] <= bus.s_data;
            end
        end
    end

    // Result register: snapshot of the core output at the end of COMPUTE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NN; k++) begin
                r_c[k] <= '0;
            end
        end else if (w_capture) begin
            for (int k = 0; k < NN; k++) begin
                r_c[k] <= C_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Flat operand buses to the core
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NN; g++) begin : g_pack
            assign A_flat[g*WIDTH +: WIDTH] = r_a[g];
            assign B_flat[g*WIDTH +: WIDTH] = r_b[g];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stream and status outputs (valid never depends on ready)
    // ------------------------------------------------------------------------
    assign bus.s_ready = w_in_load;
    assign bus.m_valid = w_in_drain;
    assign bus.m_data  = r_c[r_out_cnt];
    assign bus.m_last  = w_in_drain && (r_out_cnt == c_OUT_LAST);
    assign busy        = !w_in_load;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: doc/matmul_ctrl.md
Name: matmul_ctrl

Overview:
- Sequencer and stream adapter in front of the registered-tree matrix multiplier core `matmul_top`.
- Accepts one NxN operand pair as a serial element stream and holds the operands in registers driving the core's flat inputs.
- Waits out the core latency, captures the flat result, and replays it as a serial output stream with last-beat marking.
- One matrix product is in flight at a time.

Parameters:
- N, 4, matrix dimension (NxN). N >= 2.
- WIDTH, 8, element width in bits for A, B and C.
- LATENCY, $clog2(N), number of clock cycles from a change on A_flat/B_flat until C_flat is valid. 0 means a purely combinational core.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- s_data  in  WIDTH  input element
- s_valid  in  1  input element valid
- s_ready  out  1  controller can accept an input element
- m_data  out  WIDTH  result element
- m_valid  out  1  result element valid
- m_ready  in  1  downstream accepts the result element
- m_last  out  1  marks the final result element (index N*N-1)
- A_flat  out  N*N*WIDTH  operand A to the core
- B_flat  out  N*N*WIDTH  operand B to the core
- C_flat  in  N*N*WIDTH  result from the core
- busy  out  1  high in COMPUTE or DRAIN
- done  out  1  one-cycle pulse after the final result handshake

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rstn).
- Packing: element (i,j) occupies bits [(i*N+j)*WIDTH +: WIDTH] of A_flat, B_flat and C_flat.
- Stream order: A in row-major order (N*N beats), then B in row-major order (N*N beats). Results are output in row-major order.
- Handshake: a beat transfers on a rising edge where valid && ready. Valid must not depend on ready.
- Reset value: state=LOAD; all counters 0; A/B/C registers 0.
- Reset value of outputs: s_ready=1, m_valid=0, m_last=0, m_data=0, busy=0, done=0, A_flat=0, B_flat=0.
- LOAD state:
  - s_ready=1.
  - Each accepted beat is written to the element addressed by the input counter (0..2*N*N-1): indices below N*N go to A, the rest to B.
  - Idle cycles (s_valid=0) do not advance the counter.
  - On acceptance of beat 2*N*N-1: input counter wraps to 0, move to COMPUTE, s_ready=0 from the next cycle.
- COMPUTE state:
  - Lasts exactly LATENCY+1 cycles, counted by a wait counter.
  - A_flat/B_flat are held stable.
  - On the final COMPUTE cycle's edge, C_flat is captured into the output register; move to DRAIN.
- DRAIN state:
  - m_valid=1; m_data = captured element addressed by the output counter.
  - m_last=1 when the output counter = N*N-1.
  - The output counter advances only on an m_valid && m_ready handshake.
  - If m_ready is held low, m_data and m_last remain stable.
  - After the handshake of element N*N-1: m_valid=0, the counter wraps to 0, done=1 for exactly one cycle, return to LOAD.
- Loading cannot overlap COMPUTE or DRAIN: s_ready=0 in both.
- The first beat of the next product can be accepted in the cycle done is high.
- Minimum period per product: 2*N*N + (LATENCY+1) + N*N cycles.
- Arithmetic: the controller performs no arithmetic on data. Results are the core's WIDTH-bit values, i.e. modulo 2^WIDTH truncation of the exact sums.
- Registers are not cleared between products. A_flat/B_flat keep their previous contents until overwritten during LOAD.
- rstn asserted mid-operation: immediate return to the reset state from any state. Partially loaded data is discarded, and no done pulse is generated.
- Input beats presented while s_ready=0 are not consumed. The source must hold them.

Test Plan:
- Reset, then stream A(i,j)=i*N+j and B=all 1 (N=4, no gaps) with m_ready=1 -> s_ready falls after beat 31. m_valid rises LATENCY+1 (=3) cycles later. Output rows are 6,6,6,6 / 22×4 / 38×4 / 54×4. m_last on beat 15. done pulses once.
- A=all 10, B=all 10 -> every result = 400 mod 256 = 144.
- Random s_valid gaps (~50%) during load, with random A/B in 0..10 -> results match the software model. The input counter advances only on handshakes.
- m_ready toggled randomly during DRAIN -> no element dropped or duplicated; m_data/m_last stable while stalled; exactly 16 handshakes.
- Assert rstn low after 10 accepted beats, release, then load a full pair -> the earlier beats are ignored, the result matches only the new pair, and no done pulse occurs before the new drain completes.
- Two products back-to-back, with the first beat of the second product presented in the done cycle -> the beat is accepted, and both result sets are correct.
